// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory responder: controller states and word geometry.
package prog_mem_pkg;
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_W_DEF     = 12;
  localparam int DEPTH_DEF      = 4096;
  localparam int DATA_W_DEF     = 32;
endpackage

// File: rtl/prog_mem_responder_byte_packer.sv
// Packs loader bytes little-endian into words; a flush on the last byte zero-pads the upper lanes.
module byte_packer
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [7:0]        byte_i,
  input  logic              last_i,
  output logic              word_vld_o,
  output logic [DATA_W-1:0] word_o
);
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] pack_q;

  // Lanes above the current byte read as zero, so stale pack_q contents never leak out.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i < int'(cnt_q)) word_o[8*i +: 8] = pack_q[8*i +: 8];
      else if (i == int'(cnt_q)) word_o[8*i +: 8] = byte_i;
    end
  end

  assign word_vld_o = vld_i & (last_i | (cnt_q == 2'd3));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (vld_i) cnt_d = word_vld_o ? 2'd0 : cnt_q + 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    if (vld_i && !clr_i) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (i == int'(cnt_q)) pack_q[8*i +: 8] <= byte_i;
      end
    end
  end
endmodule

// File: rtl/prog_mem_responder.sv
// Dual-port word memory for the core plus a byte-stream program loader that owns HLT and the core reset.
module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDRA,
  output logic [DATA_W-1:0] IR,
  input  logic              WA,
  input  logic [ADDR_W-1:0] ADDRB,
  input  logic [DATA_W-1:0] DINB,
  input  logic              WB,
  output logic [DATA_W-1:0] DOUTB,
  output logic              HLT,
  output logic              PROC_RST,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_BYTE,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LD_ERR,
  output logic [ADDR_W:0]   LD_WORDS
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W:0]   waddr_q, waddr_d;
  logic              err_q, err_d;
  logic              rel_q, rel_d;
  logic              pk_vld, pk_clr, pk_word_vld;
  logic [DATA_W-1:0] pk_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_wa;

  assign unused_wa = WA;

  assign IR    = mem[ADDRA];
  assign DOUTB = mem[ADDRB];

  assign pk_vld = LD_VALID & (state_q == ST_LOAD);

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (pk_clr),
    .vld_i      (pk_vld),
    .byte_i     (LD_BYTE),
    .last_i     (LD_LAST),
    .word_vld_o (pk_word_vld),
    .word_o     (pk_word)
  );

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    err_d     = err_q;
    rel_d     = 1'b0;
    pk_clr    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ADDRB;
    mem_wdata = DINB;
    case (state_q)
      ST_HALT: begin
        if (LD_START) begin
          state_d = ST_LOAD;
          waddr_d = '0;
          err_d   = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        mem_we = WB;
        if (LD_START) begin
          state_d = ST_LOAD;
          waddr_d = '0;
          err_d   = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        // A word that would land past the array is dropped and the session is poisoned.
        if (pk_word_vld) begin
          if (waddr_q == FULL) begin
            err_d   = 1'b1;
            state_d = LD_LAST ? ST_HALT : ST_DRAIN;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = waddr_q[ADDR_W-1:0];
            mem_wdata = pk_word;
            waddr_d   = waddr_q + (ADDR_W+1)'(1);
            if (LD_LAST) begin
              state_d = ST_RUN;
              rel_d   = 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (LD_VALID && LD_LAST) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HALT;
      waddr_q <= '0;
      err_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
      rel_q   <= rel_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign HLT      = RST | (state_q != ST_RUN);
  assign PROC_RST = RST | rel_q;
  assign LD_READY = ~RST & ((state_q == ST_LOAD) | (state_q == ST_DRAIN));
  assign LD_ERR   = err_q;
  assign LD_WORDS = waddr_q;
endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed bench for prog_mem_responder: transaction-level memory/loader model plus literal checkpoints.
module tb_prog_mem_responder;
  localparam int AW = 12;
  localparam int DP = 4096;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] ADDRA, ADDRB;
  logic [31:0]   IR, DINB, DOUTB;
  logic          WA, WB, HLT, PROC_RST;
  logic          LD_START, LD_VALID, LD_LAST, LD_READY, LD_ERR;
  logic [7:0]    LD_BYTE;
  logic [AW:0]   LD_WORDS;

  int n_tests = 0;
  int n_fail  = 0;

  prog_mem_responder dut (
    .CLK(CLK), .RST(RST), .ADDRA(ADDRA), .IR(IR), .WA(WA), .ADDRB(ADDRB), .DINB(DINB),
    .WB(WB), .DOUTB(DOUTB), .HLT(HLT), .PROC_RST(PROC_RST), .LD_START(LD_START),
    .LD_VALID(LD_VALID), .LD_BYTE(LD_BYTE), .LD_LAST(LD_LAST), .LD_READY(LD_READY),
    .LD_ERR(LD_ERR), .LD_WORDS(LD_WORDS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=halted idle, 1=loading, 2=discarding, 3=core running.
  int          m_mode = 0;
  int          m_words = 0;
  bit          m_err = 0;
  bit          m_pulse = 0;
  bit          m_init = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_mem[DP];
  bit          m_known[DP];

  task automatic m_begin_load();
    m_mode  = 1;
    m_words = 0;
    m_err   = 0;
    m_bytes.delete();
  endtask

  always @(posedge CLK) begin
    bit pulse_next;
    logic [31:0] w;
    pulse_next = 0;
    if (RST) begin
      m_mode = 0; m_words = 0; m_err = 0; m_bytes.delete(); m_init = 1;
    end else if (m_mode == 0) begin
      if (LD_START) m_begin_load();
    end else if (m_mode == 3) begin
      if (WB) begin m_mem[ADDRB] = DINB; m_known[ADDRB] = 1; end
      if (LD_START) m_begin_load();
    end else if (m_mode == 1) begin
      if (LD_VALID) begin
        m_bytes.push_back(LD_BYTE);
        if (m_bytes.size() == 4 || LD_LAST) begin
          w = 0;
          for (int i = 0; i < m_bytes.size(); i++) w = w + (32'(m_bytes[i]) << (8 * i));
          m_bytes.delete();
          if (m_words == DP) begin
            m_err  = 1;
            m_mode = LD_LAST ? 0 : 2;
          end else begin
            m_mem[m_words] = w; m_known[m_words] = 1;
            m_words++;
            if (LD_LAST) begin m_mode = 3; pulse_next = 1; end
          end
        end
      end
    end else begin
      if (LD_VALID && LD_LAST) m_mode = 0;
    end
    m_pulse = pulse_next;
  end

  always @(negedge CLK) begin
    if (m_init && !RST) begin
      chk("HLT", 32'(HLT), 32'(m_mode != 3));
      chk("PROC_RST", 32'(PROC_RST), 32'(m_pulse));
      chk("LD_READY", 32'(LD_READY), 32'(m_mode == 1 || m_mode == 2));
      chk("LD_ERR", 32'(LD_ERR), 32'(m_err));
      chk("LD_WORDS", 32'(LD_WORDS), 32'(m_words));
      if (m_known[ADDRA]) chk("IR", IR, m_mem[ADDRA]);
      if (m_known[ADDRB]) chk("DOUTB", DOUTB, m_mem[ADDRB]);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    LD_VALID = 1'b1; LD_BYTE = b; LD_LAST = last;
    step();
    LD_VALID = 1'b0; LD_LAST = 1'b0;
  endtask

  task automatic start_load();
    LD_START = 1'b1;
    step();
    LD_START = 1'b0;
  endtask

  initial begin
    logic [7:0] first8[8];
    first8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    RST = 1'b1; ADDRA = '0; ADDRB = '0; DINB = '0; WA = 1'b0; WB = 1'b0;
    LD_START = 1'b0; LD_VALID = 1'b0; LD_BYTE = '0; LD_LAST = 1'b0;
    step(); step();
    chk("rst_HLT", 32'(HLT), 32'd1);
    chk("rst_PROC_RST", 32'(PROC_RST), 32'd1);
    chk("rst_LD_READY", 32'(LD_READY), 32'd0);
    chk("rst_LD_ERR", 32'(LD_ERR), 32'd0);
    chk("rst_LD_WORDS", 32'(LD_WORDS), 32'd0);
    RST = 1'b0;
    step();
    chk("idle_PROC_RST", 32'(PROC_RST), 32'd0);

    // Two-word load with a 5-cycle stall after the 6th byte.
    start_load();
    chk("load_READY", 32'(LD_READY), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(first8[i], i == 7);
      if (i == 5) begin
        repeat (5) step();
        chk("stall_WORDS", 32'(LD_WORDS), 32'd1);
      end
    end
    chk("rel_PROC_RST", 32'(PROC_RST), 32'd1);
    chk("rel_HLT", 32'(HLT), 32'd0);
    step();
    chk("run_PROC_RST", 32'(PROC_RST), 32'd0);
    ADDRA = 12'd0; ADDRB = 12'd1; #1;
    chk("mem0", IR, 32'h44332211);
    chk("mem1", DOUTB, 32'h88776655);
    chk("words2", 32'(LD_WORDS), 32'd2);

    // Partial word from RUN.
    start_load();
    chk("reload_HLT", 32'(HLT), 32'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    step();
    chk("partial_mem0", IR, 32'h0000BBAA);
    chk("partial_mem1", DOUTB, 32'h88776655);
    chk("partial_words", 32'(LD_WORDS), 32'd1);
    chk("partial_HLT", 32'(HLT), 32'd0);

    // Core store in RUN, then the same store attempted while halted.
    ADDRB = 12'h010; DINB = 32'hDEADBEEF; WB = 1'b1;
    step();
    WB = 1'b0;
    chk("run_store", DOUTB, 32'hDEADBEEF);
    RST = 1'b1; step(); RST = 1'b0; step();
    DINB = 32'h12345678; WB = 1'b1;
    step(); step();
    WB = 1'b0;
    chk("halt_store_ignored", DOUTB, 32'hDEADBEEF);

    // Reset in the middle of the second word.
    start_load();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    RST = 1'b1; step(); RST = 1'b0;
    ADDRA = 12'd0; ADDRB = 12'd1; #1;
    chk("rst_mid_mem0", IR, 32'h04030201);
    chk("rst_mid_mem1", DOUTB, 32'h88776655);
    chk("rst_mid_HLT", 32'(HLT), 32'd1);
    chk("rst_mid_READY", 32'(LD_READY), 32'd0);
    step();

    // Overflow: one word beyond the array, then drain until LAST.
    start_load();
    for (int i = 0; i < 4 * DP + 4; i++) send_byte(8'(i), 1'b0);
    chk("ovf_ERR", 32'(LD_ERR), 32'd1);
    chk("ovf_WORDS", 32'(LD_WORDS), 32'd4096);
    chk("drain_READY", 32'(LD_READY), 32'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    chk("drain_end_READY", 32'(LD_READY), 32'd0);
    chk("drain_end_HLT", 32'(HLT), 32'd1);
    chk("drain_end_PROC_RST", 32'(PROC_RST), 32'd0);
    chk("drain_end_ERR", 32'(LD_ERR), 32'd1);
    ADDRA = 12'd0; ADDRB = 12'd4095; #1;
    chk("ovf_mem0", IR, 32'h03020100);
    chk("ovf_mem4095", DOUTB, 32'hFFFEFDFC);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
